// File: rtl/z_match_monitor.sv
// Statistics monitor for the five-state w/z sequence detector: counts z rises,
// tracks current/longest z-high runs and captures the first non-one-hot state.
module z_match_monitor #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic [4:0]       state,
  input  logic             clr,
  output logic             z_rise,
  output logic [CNT_W-1:0] match_cnt,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic             onehot_err,
  output logic [4:0]       err_state
);

  logic             z_q,         z_d;
  logic             zRise_q,     zRise_d;
  logic [CNT_W-1:0] matchCnt_q,  matchCnt_d;
  logic [RUN_W-1:0] runLen_q,    runLen_d;
  logic [RUN_W-1:0] maxRun_q,    maxRun_d;
  logic             onehotErr_q, onehotErr_d;
  logic [4:0]       errState_q,  errState_d;

  logic rise;
  logic illegal;

  assign rise    = z & ~z_q;
  assign illegal = ($countones(state) != 1);

  always_comb begin
    z_d         = z;
    zRise_d     = rise;
    matchCnt_d  = matchCnt_q;
    runLen_d    = '0;
    maxRun_d    = maxRun_q;
    onehotErr_d = onehotErr_q;
    errState_d  = errState_q;

    if (rise && (matchCnt_q != {CNT_W{1'b1}}))
      matchCnt_d = matchCnt_q + 1'b1;

    if (z)
      runLen_d = (runLen_q == {RUN_W{1'b1}}) ? runLen_q : runLen_q + 1'b1;

    // Longest run is compared against the updated run length, not the old one.
    if (runLen_d > maxRun_q)
      maxRun_d = runLen_d;

    if (illegal && !onehotErr_q) begin
      onehotErr_d = 1'b1;
      errState_d  = state;
    end

    // Clear wipes statistics but z history still tracks z, so no false rise.
    if (clr) begin
      zRise_d     = 1'b0;
      matchCnt_d  = '0;
      runLen_d    = '0;
      maxRun_d    = '0;
      onehotErr_d = 1'b0;
      errState_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      z_q         <= 1'b0;
      zRise_q     <= 1'b0;
      matchCnt_q  <= '0;
      runLen_q    <= '0;
      maxRun_q    <= '0;
      onehotErr_q <= 1'b0;
      errState_q  <= '0;
    end else begin
      z_q         <= z_d;
      zRise_q     <= zRise_d;
      matchCnt_q  <= matchCnt_d;
      runLen_q    <= runLen_d;
      maxRun_q    <= maxRun_d;
      onehotErr_q <= onehotErr_d;
      errState_q  <= errState_d;
    end
  end

  assign z_rise     = zRise_q;
  assign match_cnt  = matchCnt_q;
  assign run_len    = runLen_q;
  assign max_run    = maxRun_q;
  assign onehot_err = onehotErr_q;
  assign err_state  = errState_q;

endmodule

// File: tb/tb_z_match_monitor.sv
// Directed bench for z_match_monitor; a second instance with CNT_W=2 shares
// the stimulus so match-count saturation can be observed.
module tb_z_match_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       z;
  logic [4:0] state;
  logic       clr;

  logic       zRise,   zRise2;
  logic [7:0] matchCnt;
  logic [1:0] matchCnt2;
  logic [3:0] runLen,  runLen2;
  logic [3:0] maxRun,  maxRun2;
  logic       onehotErr, onehotErr2;
  logic [4:0] errState,  errState2;

  int errors = 0;
  int checks = 0;
  int risePulses;

  always #5 clk = ~clk;

  z_match_monitor #(.CNT_W(8), .RUN_W(4)) dut (
    .clk(clk), .reset(reset), .z(z), .state(state), .clr(clr),
    .z_rise(zRise), .match_cnt(matchCnt), .run_len(runLen), .max_run(maxRun),
    .onehot_err(onehotErr), .err_state(errState)
  );

  z_match_monitor #(.CNT_W(2), .RUN_W(4)) dutSmall (
    .clk(clk), .reset(reset), .z(z), .state(state), .clr(clr),
    .z_rise(zRise2), .match_cnt(matchCnt2), .run_len(runLen2), .max_run(maxRun2),
    .onehot_err(onehotErr2), .err_state(errState2)
  );

  // Drive one cycle of inputs, then sample 1 ns after the clock edge.
  task automatic applyStimulus(input logic rstN, input logic zIn,
                               input logic [4:0] stIn, input logic clrIn);
    reset = rstN;
    z     = zIn;
    state = stIn;
    clr   = clrIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eRise, input int eCnt,
                          input int eRun, input int eMax, input int eErr, input int eSt);
    checkOutput({tag, ".z_rise"},     int'(zRise),     eRise);
    checkOutput({tag, ".match_cnt"},  int'(matchCnt),  eCnt);
    checkOutput({tag, ".run_len"},    int'(runLen),    eRun);
    checkOutput({tag, ".max_run"},    int'(maxRun),    eMax);
    checkOutput({tag, ".onehot_err"}, int'(onehotErr), eErr);
    checkOutput({tag, ".err_state"},  int'(errState),  eSt);
  endtask

  initial begin
    reset = 1'b0; z = 1'b0; state = 5'b00001; clr = 1'b0;
    #1;

    // Reset held low for two cycles, then released with z low.
    applyStimulus(1'b0, 1'b0, 5'b00001, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'b00001, 1'b0);
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b0);
    checkAll("release", 0, 0, 0, 0, 0, 0);

    // High 3, low 2, high 1.
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    checkAll("t2.c1", 1, 1, 1, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 5'b00010, 1'b0);
    checkAll("t2.c2", 0, 1, 2, 2, 0, 0);
    applyStimulus(1'b1, 1'b1, 5'b00100, 1'b0);
    checkAll("t2.c3", 0, 1, 3, 3, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'b01000, 1'b0);
    checkAll("t2.c4", 0, 1, 0, 3, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'b10000, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    checkAll("t2.c6", 1, 2, 1, 3, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b0);
    checkAll("t2.c7", 0, 2, 0, 3, 0, 0);

    // Saturation of a 2-bit match counter over five rises.
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b1);
    checkAll("t3.clr", 0, 0, 0, 0, 0, 0);
    checkOutput("t3.clr.small_cnt", int'(matchCnt2), 0);
    risePulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
      if (zRise2) risePulses++;
      applyStimulus(1'b1, 1'b0, 5'b00001, 1'b0);
      if (zRise2) risePulses++;
    end
    checkOutput("t3.small_pulses", risePulses, 5);
    checkOutput("t3.small_cnt", int'(matchCnt2), 3);
    checkOutput("t3.wide_cnt", int'(matchCnt), 5);

    // Long run saturates run_len and max_run at 15.
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
      if (i == 14) checkOutput("t4.run14", int'(runLen), 14);
      if (i == 15) checkOutput("t4.run15", int'(runLen), 15);
    end
    checkOutput("t4.run20", int'(runLen), 15);
    checkOutput("t4.max20", int'(maxRun), 15);
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b0);
    checkOutput("t4.run_low", int'(runLen), 0);
    checkOutput("t4.max_low", int'(maxRun), 15);

    // First illegal vector captured and kept; z rise in the same cycle still counted.
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'b00110, 1'b0);
    checkAll("t5.first", 1, 1, 1, 1, 1, 6);
    applyStimulus(1'b1, 1'b0, 5'b00000, 1'b0);
    checkAll("t5.second", 0, 1, 0, 1, 1, 6);
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b1);
    checkAll("t5.clr", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'b00001, 1'b0);
    checkOutput("t5.after_clr_err", int'(onehotErr), 0);

    // Clear mid-run: no false rise afterwards.
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    checkAll("t6.run1", 1, 1, 1, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b1);
    checkAll("t6.clr", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    checkAll("t6.post_clr", 0, 0, 1, 1, 0, 0);

    // Reset mid-run: z history is lost, so the first sample after release is a rise.
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0);
    checkAll("t6.reset", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 5'b00001, 1'b0);
    checkAll("t6.release", 1, 1, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
